// File: rtl/secuenciador_bloques_datos.sv
// Data-block sequencer: arbitrates init/date/time/read requests and walks the RTC slots,
// handshaking each one with the bus access engine through inicio_acc/acc_listo.
module secuenciador_bloques_datos #(
    parameter int unsigned PERIODO_LECT = 1_000_000,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_init,
    input  logic       req_esc_fecha,
    input  logic       req_esc_hora,
    input  logic       acc_listo,
    output logic [3:0] Selec_Mux_DD,
    output logic       inicio_acc,
    output logic       escritura,
    output logic       ocupado,
    output logic       fin_secuencia,
    output logic       error_acc
);

    localparam int unsigned PW = (PERIODO_LECT > 1) ? $clog2(PERIODO_LECT) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StArranque, StEspera} estado_t;
    typedef enum logic [1:0] {SeqInit, SeqFecha, SeqHora, SeqLect} secuencia_t;

    estado_t    estado_q, estado_d;
    secuencia_t sec_q, sec_d, sec_sel;
    logic [3:0] sel_q, sel_d;
    logic [2:0] idx_q, idx_d;
    logic       esc_q, esc_d;
    logic       fin_q, fin_d;
    logic       err_q, err_d;
    logic [TW-1:0] cnt_to_q, cnt_to_d;
    logic [PW-1:0] cnt_per_q, cnt_per_d;
    logic       pend_init_q, pend_init_d;
    logic       pend_fecha_q, pend_fecha_d;
    logic       pend_hora_q, pend_hora_d;
    logic       pend_lect_q, pend_lect_d;
    logic       hay_pend, concede, rearm_init, wrap;

    function automatic logic [3:0] primer_slot(input secuencia_t s);
        case (s)
            SeqInit:  primer_slot = 4'b0000;
            SeqFecha: primer_slot = 4'b0011;
            SeqHora:  primer_slot = 4'b0110;
            default:  primer_slot = 4'b0011;
        endcase
    endfunction

    function automatic logic [2:0] ultimo_idx(input secuencia_t s);
        ultimo_idx = (s == SeqLect) ? 3'd5 : 3'd2;
    endfunction

    // Fixed priority among pending requests: init > hora > fecha > lectura.
    always_comb begin
        sec_sel  = SeqLect;
        hay_pend = 1'b1;
        if (pend_init_q) begin
            sec_sel = SeqInit;
        end else if (pend_hora_q) begin
            sec_sel = SeqHora;
        end else if (pend_fecha_q) begin
            sec_sel = SeqFecha;
        end else if (!pend_lect_q) begin
            hay_pend = 1'b0;
        end
    end

    assign concede = (estado_q == StIdle) && hay_pend;
    assign wrap    = (cnt_per_q == PW'(PERIODO_LECT - 1));

    always_comb begin
        estado_d   = estado_q;
        sec_d      = sec_q;
        sel_d      = sel_q;
        idx_d      = idx_q;
        esc_d      = esc_q;
        fin_d      = 1'b0;
        err_d      = 1'b0;
        cnt_to_d   = cnt_to_q;
        rearm_init = 1'b0;
        unique case (estado_q)
            StIdle: begin
                if (hay_pend) begin
                    estado_d = StArranque;
                    sec_d    = sec_sel;
                    sel_d    = primer_slot(sec_sel);
                    idx_d    = 3'd0;
                    esc_d    = (sec_sel != SeqLect);
                end
            end
            StArranque: begin
                estado_d = StEspera;
                cnt_to_d = '0;
            end
            StEspera: begin
                // acc_listo is checked before the timeout so it wins a tie.
                if (acc_listo) begin
                    if (idx_q == ultimo_idx(sec_q)) begin
                        fin_d    = 1'b1;
                        estado_d = StIdle;
                        sel_d    = 4'b1111;
                        esc_d    = 1'b0;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        sel_d    = sel_q + 4'd1;
                        estado_d = StArranque;
                    end
                end else if (cnt_to_q == TW'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    estado_d   = StIdle;
                    sel_d      = 4'b1111;
                    esc_d      = 1'b0;
                    rearm_init = (sec_q == SeqInit);
                end else begin
                    cnt_to_d = cnt_to_q + TW'(1);
                end
            end
            default: begin
                estado_d = StIdle;
                sel_d    = 4'b1111;
                esc_d    = 1'b0;
            end
        endcase
    end

    // A request seen in the grant cycle itself re-arms its flag (set beats clear).
    always_comb begin
        cnt_per_d    = wrap ? '0 : cnt_per_q + PW'(1);
        pend_init_d  = req_init | rearm_init | (pend_init_q & ~(concede && sec_sel == SeqInit));
        pend_hora_d  = req_esc_hora | (pend_hora_q & ~(concede && sec_sel == SeqHora));
        pend_fecha_d = req_esc_fecha | (pend_fecha_q & ~(concede && sec_sel == SeqFecha));
        pend_lect_d  = wrap | (pend_lect_q & ~(concede && sec_sel == SeqLect));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q     <= StIdle;
            sec_q        <= SeqInit;
            sel_q        <= 4'b1111;
            idx_q        <= 3'd0;
            esc_q        <= 1'b0;
            fin_q        <= 1'b0;
            err_q        <= 1'b0;
            cnt_to_q     <= '0;
            cnt_per_q    <= '0;
            pend_init_q  <= 1'b1;
            pend_fecha_q <= 1'b0;
            pend_hora_q  <= 1'b0;
            pend_lect_q  <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            sec_q        <= sec_d;
            sel_q        <= sel_d;
            idx_q        <= idx_d;
            esc_q        <= esc_d;
            fin_q        <= fin_d;
            err_q        <= err_d;
            cnt_to_q     <= cnt_to_d;
            cnt_per_q    <= cnt_per_d;
            pend_init_q  <= pend_init_d;
            pend_fecha_q <= pend_fecha_d;
            pend_hora_q  <= pend_hora_d;
            pend_lect_q  <= pend_lect_d;
        end
    end

    assign Selec_Mux_DD  = sel_q;
    assign inicio_acc    = (estado_q == StArranque);
    assign escritura     = esc_q;
    assign ocupado       = (estado_q != StIdle);
    assign fin_secuencia = fin_q;
    assign error_acc     = err_q;

endmodule
